shift_sub_divider: RTL
======================

Name: shift_sub_divider

Overview:
- Sequential restoring (shift-subtract) integer divider; the inverse operation to the team's shift-add multiplier.
- Same start/ready handshake and `sign` mode select, so both blocks drop into the same arithmetic datapath slot.
- Produces quotient and remainder one bit per clock.

Parameters:
- DIV_WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a division; sampled only while ready=1.
- sign  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- data_in1  input  DIV_WIDTH  dividend; sampled with start.
- data_in2  input  DIV_WIDTH  divisor; sampled with start.
- quotient  output  DIV_WIDTH  registered quotient of the last completed operation.
- remainder  output  DIV_WIDTH  registered remainder of the last completed operation.
- div_by_zero  output  1  registered; 1 if the last completed operation had divisor 0.
- ready  output  1  1 = idle, results valid, new start accepted.

Behaviour:
- Reset:
  - ready=1, quotient=0, remainder=0, div_by_zero=0.
  - Internal state goes to IDLE with counter=0.
  - Reset has priority over everything and aborts any operation in flight; no partial result is written.
- FSM states:
  - IDLE: ready=1. start=1 at edge E0 → latch |dividend|, |divisor|, sign flags, sign mode and zero-divisor flag; clear partial remainder; counter=0; ready<=0; go to RUN.
  - RUN: each edge performs one iteration:
    - Shift {rem, quo} left by 1, bringing in the next dividend bit.
    - trial = rem − divisor, computed DIV_WIDTH+1 bits wide.
    - If trial is non-negative: rem<=trial and quo LSB=1; otherwise keep rem and quo LSB=0.
    - counter increments.
  - Completion: on the edge that performs iteration DIV_WIDTH (edge E_DIV_WIDTH), write outputs, set ready<=1 and return to IDLE.
  - Latency is fixed: ready rises DIV_WIDTH edges after the start edge, independent of operand values.
- Signed mode (sign=1):
  - Magnitudes are taken at load.
  - Quotient is negated if the dividend and divisor sign bits differ, giving truncation toward zero.
  - Remainder is negated if the dividend was negative, so the remainder takes the dividend's sign.
  - Overflow case, most-negative / −1: quotient wraps to the most-negative value (e.g. 4'b1000); remainder=0; no flag.
- Unsigned mode (sign=0): no negation at load or at output.
- Divide by zero (divisor==0, either mode):
  - quotient=all ones.
  - remainder=original dividend bits, not sign-adjusted.
  - div_by_zero=1.
- Outputs on completion:
  - quotient, remainder and div_by_zero change only on the completion edge (or on reset).
  - They hold their previous values throughout RUN.
  - div_by_zero is cleared on every non-zero-divisor completion.
- Handshake:
  - start while ready=0 is ignored; data_in1, data_in2 and sign may change freely during RUN.
  - start held high continuously: a new operation is accepted at the first edge where ready=1, i.e. one edge after completion.
  - Back-to-back throughput is DIV_WIDTH+1 cycles per operation.
- Width rules: counter width is $clog2(DIV_WIDTH+1). The partial remainder is DIV_WIDTH+1 bits internally so the trial subtract cannot alias.

Optional Feature:
- Macro: SHIFT_SUB_DIVIDER_DBZ_FAST_EN.
- Defined: a zero divisor is detected at the start edge E0. The block skips RUN and writes the divide-by-zero results with ready=1 at edge E1. Latency for that case is 1.
- Not defined: divide by zero runs all DIV_WIDTH iterations and completes at E_DIV_WIDTH with the same result values. Latency is uniform.

Test Plan:
- Unsigned, DIV_WIDTH=4: start with in1=13, in2=3, sign=0 → ready low for 4 cycles, then quotient=4, remainder=1, div_by_zero=0.
- Signed: in1=4'b1001 (−7), in2=2, sign=1 → quotient=4'b1101 (−3), remainder=4'b1111 (−1). Also in1=7, in2=4'b1110 (−2) → quotient=4'b1101, remainder=1.
- Signed overflow: in1=4'b1000, in2=4'b1111, sign=1 → quotient=4'b1000, remainder=0, div_by_zero=0.
- Divide by zero: in1=9, in2=0, sign=0 → quotient=4'b1111, remainder=4'b1001, div_by_zero=1. Latency is 4 without the macro and 1 with it. Repeat with sign=1, in1=4'b1001 → quotient=4'b1111, remainder=4'b1001.
- Busy/back-to-back: pulse start with 13/3, then change operands and pulse start again at cycle 2 → second start ignored, result 4/1. Then hold start=1 → next operation accepted exactly one edge after ready rises.
- Reset mid-operation: assert rst at iteration 2 of 13/3 → next cycle ready=1, quotient=0, remainder=0, div_by_zero=0. A subsequent 6/2 completes correctly with quotient=3, remainder=0.

Source files
------------

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential restoring (shift-subtract) integer divider.
// Produces one quotient bit per clock; start/ready handshake, sign selects
// two's-complement (1) or unsigned (0) operands.
// Optional macro SHIFT_SUB_DIVIDER_DBZ_FAST_EN: a zero divisor completes one
// edge after start instead of running all DIV_WIDTH iterations.
module shift_sub_divider #(
  parameter int DIV_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sign,
  input  logic [DIV_WIDTH-1:0] data_in1,
  input  logic [DIV_WIDTH-1:0] data_in2,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 div_by_zero,
  output logic                 ready
);

  localparam int CW = $clog2(DIV_WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [DIV_WIDTH-1:0] rem;        // partial remainder, always < divisor
  logic [DIV_WIDTH-1:0] quo;        // dividend bits shift out, quotient bits shift in
  logic [DIV_WIDTH-1:0] dvsr;       // divisor magnitude
  logic [DIV_WIDTH-1:0] dvnd_raw;   // original dividend bits for the zero-divisor result
  logic                 neg_q;
  logic                 neg_r;
  logic                 dbz;

  logic [DIV_WIDTH-1:0] a_mag;
  logic [DIV_WIDTH-1:0] b_mag;
  logic [DIV_WIDTH:0]   rem_sh;
  logic [DIV_WIDTH:0]   trial;
  logic                 q_bit;
  logic [DIV_WIDTH-1:0] q_fin;
  logic [DIV_WIDTH-1:0] r_fin;
  logic                 fast_dbz;
  logic                 load;
  logic                 last;

`ifdef SHIFT_SUB_DIVIDER_DBZ_FAST_EN
  assign fast_dbz = dbz;
`else
  assign fast_dbz = 1'b0;
`endif

  assign ready = (state == IDLE);
  assign load  = (state == IDLE) && start;
  assign last  = (state == RUN) && ((cnt == CW'(DIV_WIDTH - 1)) || fast_dbz);

  // Operand magnitudes and one restoring iteration.
  // The shifted remainder is DIV_WIDTH+1 bits; since rem < divisor before the
  // shift, the true trial lies in signed (DIV_WIDTH+1)-bit range and its MSB is
  // the sign. The stored remainder therefore only needs DIV_WIDTH bits.
  always_comb begin
    a_mag  = (sign && data_in1[DIV_WIDTH-1]) ? -data_in1 : data_in1;
    b_mag  = (sign && data_in2[DIV_WIDTH-1]) ? -data_in2 : data_in2;
    rem_sh = {rem, quo[DIV_WIDTH-1]};
    trial  = rem_sh - {1'b0, dvsr};
    q_bit  = ~trial[DIV_WIDTH];
    q_fin  = {quo[DIV_WIDTH-2:0], q_bit};
    r_fin  = q_bit ? trial[DIV_WIDTH-1:0] : rem_sh[DIV_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand load, iteration, and result write on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      dvnd_raw    <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz         <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= a_mag;
      dvsr     <= b_mag;
      dvnd_raw <= data_in1;
      neg_q    <= sign & (data_in1[DIV_WIDTH-1] ^ data_in2[DIV_WIDTH-1]);
      neg_r    <= sign & data_in1[DIV_WIDTH-1];
      dbz      <= (data_in2 == '0);
    end else if (state == RUN) begin
      rem <= r_fin;
      quo <= q_fin;
      cnt <= cnt + 1'b1;
      if (last) begin
        cnt <= '0;
        if (dbz) begin
          quotient    <= '1;
          remainder   <= dvnd_raw;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= neg_q ? -q_fin : q_fin;
          remainder   <= neg_r ? -r_fin : r_fin;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule
